// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Two-requester byte scheduler in front of a UART transmitter. A requester
// raises its level request; the scheduler arbitrates round-robin, captures
// that requester's 32-bit payload word and streams NBYTES bytes (LSB first)
// to the transmitter. For each byte it issues a one-cycle tx_start and then
// waits for the transmitter's tx_done pulse. After the last byte completes,
// a one-cycle done pulse is raised for the served requester.
//
// Optional build macro: UART_TXSCHED_HDR_EN
//   When defined, every frame begins with a header byte 8'hA0 | id, where
//   id is 0 or 1 for the served requester, followed by the payload bytes.
//   Each frame is then NBYTES+1 bytes long.
//
// Parameters
//   NBYTES    payload bytes per request, legal range 1..4
//
// Ports
//   clk       system clock, rising edge active
//   reset     asynchronous active-high reset
//   req0/1    level request from requester 0 / 1
//   data0/1   payload word of requester 0 / 1, sampled at grant
//   gnt0/1    one-cycle pulse marking payload capture
//   done0/1   one-cycle pulse after the last byte of the frame completes
//   tx_start  one-cycle start strobe to the transmitter
//   din       byte presented to the transmitter, stable until the next start
//   tx_done   transmitter stop-bit completion pulse
//   busy      high whenever the scheduler is not idle
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int NBYTES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        tx_start,
    output logic [7:0]  din,
    input  logic        tx_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

`ifdef UART_TXSCHED_HDR_EN
    localparam int HDR_BYTES = 1;
`else
    localparam int HDR_BYTES = 0;
`endif

    // Bytes per frame and the index of the final byte.
    localparam int         FRAME_LEN = NBYTES + HDR_BYTES;
    localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

    // Byte k of a payload word, least significant byte first.
    function automatic logic [7:0] payload_byte(input logic [31:0] word,
                                                input logic [2:0]  k);
        logic [7:0] b;
        case (k)
            3'd0:    b = word[7:0];
            3'd1:    b = word[15:8];
            3'd2:    b = word[23:16];
            3'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Byte at position idx of the frame sent on the wire.
    function automatic logic [7:0] frame_byte(input logic [31:0] word,
                                              input logic        id,
                                              input logic [2:0]  idx);
        logic [7:0] b;
`ifdef UART_TXSCHED_HDR_EN
        if (idx == 3'd0) begin
            b = 8'hA0 | {7'h00, id};
        end else begin
            b = payload_byte(word, idx - 3'd1);
        end
`else
        logic id_unused_s;
        id_unused_s = id;
        b = payload_byte(word, idx);
`endif
        return b;
    endfunction

    state_t      state_q,    state_d;
    logic [2:0]  cnt_q,      cnt_d;
    logic [31:0] word_q,     word_d;
    logic        id_q,       id_d;
    logic        last_q,     last_d;
    logic        gnt0_q,     gnt0_d;
    logic        gnt1_q,     gnt1_d;
    logic        done0_q,    done0_d;
    logic        done1_q,    done1_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  din_q,      din_d;
    logic        busy_q,     busy_d;

    logic        grant_id_s;
    logic [31:0] grant_word_s;
    logic [2:0]  next_idx_s;

    // Round-robin pick: a lone request always wins; on contention the
    // requester that was not served last goes first.
    always_comb begin
        if (req0 && req1) begin
            grant_id_s = ~last_q;
        end else begin
            grant_id_s = req1;
        end
        grant_word_s = grant_id_s ? data1 : data0;
        next_idx_s   = cnt_q + 3'd1;
    end

    // Next-state and next-output logic; outputs are computed one cycle
    // ahead so that they land in flops together with the state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        id_d       = id_q;
        last_d     = last_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        tx_start_d = 1'b0;
        din_d      = din_q;

        case (state_q)
            IDLE: begin
                // tx_done is deliberately not looked at here.
                if (req0 || req1) begin
                    state_d    = SEND;
                    cnt_d      = 3'd0;
                    word_d     = grant_word_s;
                    id_d       = grant_id_s;
                    last_d     = grant_id_s;
                    gnt0_d     = ~grant_id_s;
                    gnt1_d     = grant_id_s;
                    tx_start_d = 1'b1;
                    din_d      = frame_byte(grant_word_s, grant_id_s, 3'd0);
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                // Start strobe lasts exactly one cycle; a tx_done seen here
                // cannot belong to the byte just started, so it is ignored.
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                        done0_d = ~id_q;
                        done1_d = id_q;
                    end else begin
                        state_d    = SEND;
                        cnt_d      = next_idx_s;
                        tx_start_d = 1'b1;
                        din_d      = frame_byte(word_q, id_q, next_idx_s);
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, frame context and output registers. Reset drops any frame in
    // flight; the pointer reset value lets requester 0 win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            word_q     <= 32'h0000_0000;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            tx_start_q <= 1'b0;
            din_q      <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            id_q       <= id_d;
            last_q     <= last_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            tx_start_q <= tx_start_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign tx_start = tx_start_q;
    assign din      = din_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Self-checking bench for uart_tx_sched. Two instances share all inputs:
// u_dut4 uses the default NBYTES=4, u_dut1 uses NBYTES=1. Outputs are
// compared as one bundle {gnt0,gnt1,done0,done1,tx_start,busy,din}.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

`ifdef UART_TXSCHED_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [31:0] data0 = 32'h0;
    logic [31:0] data1 = 32'h0;
    logic        tx_done = 1'b0;

    logic        a_gnt0, a_gnt1, a_done0, a_done1, a_tx_start, a_busy;
    logic [7:0]  a_din;
    logic        b_gnt0, b_gnt1, b_done0, b_done1, b_tx_start, b_busy;
    logic [7:0]  b_din;

    int nerr = 0;
    int ncheck = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(.NBYTES(4)) u_dut4 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .done0(a_done0), .done1(a_done1),
        .tx_start(a_tx_start), .din(a_din), .tx_done(tx_done), .busy(a_busy)
    );

    uart_tx_sched #(.NBYTES(1)) u_dut1 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
        .tx_start(b_tx_start), .din(b_din), .tx_done(tx_done), .busy(b_busy)
    );

    typedef struct {
        logic        r0;
        logic        r1;
        logic        td;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [13:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [13:0] mk(input logic g0, input logic g1,
                                       input logic dn0, input logic dn1,
                                       input logic ts, input logic bz,
                                       input logic [7:0] d);
        return {g0, g1, dn0, dn1, ts, bz, d};
    endfunction

    function automatic logic [13:0] obs(input int u);
        if (u == 0) begin
            return {a_gnt0, a_gnt1, a_done0, a_done1, a_tx_start, a_busy, a_din};
        end
        return {b_gnt0, b_gnt1, b_done0, b_done1, b_tx_start, b_busy, b_din};
    endfunction

    // Expected wire byte k of a frame for requester id.
    function automatic logic [7:0] eb(input logic [31:0] w, input int id, input int k);
        logic [31:0] sh;
        if (HDR == 1 && k == 0) begin
            return 8'hA0 | 8'(id);
        end
        sh = w >> (8 * (k - HDR));
        return sh[7:0];
    endfunction

    task automatic chk(input string name, input int u, input logic [13:0] exp);
        logic [13:0] act;
        act = obs(u);
        ncheck++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s (dut%0d): got g0g1d0d1 ts bz din=%b %b %b %b %b %b %h, expected %b %b %b %b %b %b %h",
                     name, u, act[13], act[12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic add(input logic r0, input logic r1, input logic td,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [13:0] e);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.td = td; v.d0 = d0; v.d1 = d1; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic cyc(input logic r0, input logic r1, input logic td);
        @(negedge clk);
        req0 = r0;
        req1 = r1;
        tx_done = td;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        tx_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Walk the rest of a frame starting in the cycle right after the grant.
    task automatic serve_rest(input int u, input logic r0, input logic r1,
                              input logic [31:0] w, input int id, input int nb);
        int len;
        len = nb + HDR;
        cyc(r0, r1, 1'b0);
        chk("wait_b0", u, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, eb(w, id, 0)));
        for (int k = 1; k < len; k++) begin
            cyc(r0, r1, 1'b1);
            chk($sformatf("send_b%0d", k), u, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, eb(w, id, k)));
            cyc(r0, r1, 1'b0);
            chk($sformatf("wait_b%0d", k), u, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, eb(w, id, k)));
        end
        cyc(r0, r1, 1'b1);
        chk("done", u, mk(1'b0, 1'b0, (id == 0), (id == 1), 1'b0, 1'b0, eb(w, id, len - 1)));
    endtask

    initial begin
        // Reset values while reset is held.
        #2 reset = 1'b1;
        #2;
        chk("reset_state", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        chk("reset_state", 1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        @(negedge clk);
        reset = 1'b0;

`ifndef UART_TXSCHED_HDR_EN
        // Single request 11223344, data change after capture, spurious
        // tx_done in IDLE and SEND, lone req1, req0 raised and dropped while busy.
        add(1'b1, 1'b0, 1'b0, 32'h11223344, 32'h0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44));
        add(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44));
        add(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44));
        add(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33));
        add(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33));
        add(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22));
        add(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22));
        add(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11));
        add(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11));
        add(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11));
        add(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11));
        add(1'b0, 1'b1, 1'b0, 32'h0, 32'hCAFEBABE, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hBE));
        add(1'b0, 1'b0, 1'b1, 32'h0, 32'h0,        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hBE));
        add(1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hBE));
        add(1'b1, 1'b0, 1'b1, 32'h0, 32'h0,        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hBA));
        add(1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hBA));
        add(1'b0, 1'b0, 1'b1, 32'h0, 32'h0,        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFE));
        add(1'b0, 1'b0, 1'b0, 32'h0, 32'h0,        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFE));
        add(1'b0, 1'b0, 1'b1, 32'h0, 32'h0,        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hCA));
        add(1'b0, 1'b0, 1'b0, 32'h0, 32'h0,        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hCA));
        add(1'b0, 1'b0, 1'b1, 32'h0, 32'h0,        mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hCA));
        add(1'b0, 1'b0, 1'b0, 32'h0, 32'h0,        mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hCA));
`else
        // Header build: req1 with DEADBEEF -> A1, EF, BE, AD, DE, then done1.
        add(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1));
        add(1'b0, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1));
        add(1'b0, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hEF));
        add(1'b0, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hEF));
        add(1'b0, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hBE));
        add(1'b0, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hBE));
        add(1'b0, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAD));
        add(1'b0, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAD));
        add(1'b0, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hDE));
        add(1'b0, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hDE));
        add(1'b0, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hDE));
        add(1'b0, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hDE));
`endif

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            req0 = vq[i].r0;
            req1 = vq[i].r1;
            tx_done = vq[i].td;
            data0 = vq[i].d0;
            data1 = vq[i].d1;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), 0, vq[i].exp);
        end

        // Contention from reset: 0 first, 1 in the done0 cycle, then 0 again.
        do_reset();
        data0 = 32'h0A0B0C0D;
        data1 = 32'h1A1B1C1D;
        cyc(1'b1, 1'b1, 1'b0);
        chk("rr_first_gnt0", 0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, eb(data0, 0, 0)));
        serve_rest(0, 1'b1, 1'b1, 32'h0A0B0C0D, 0, 4);
        cyc(1'b1, 1'b1, 1'b0);
        chk("rr_back2back_gnt1", 0, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, eb(data1, 1, 0)));
        serve_rest(0, 1'b1, 1'b1, 32'h1A1B1C1D, 1, 4);
        cyc(1'b1, 1'b1, 1'b0);
        chk("rr_again_gnt0", 0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, eb(data0, 0, 0)));
        serve_rest(0, 1'b0, 1'b0, 32'h0A0B0C0D, 0, 4);

        // Reset after byte 1: abort, no done, no resume; req1 starts fresh.
        do_reset();
        data0 = 32'h55667788;
        cyc(1'b1, 1'b0, 1'b0);
        chk("abort_gnt0", 0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h88));
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("abort_byte1", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, eb(32'h55667788, 0, 1)));
        cyc(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_reset_vals", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'(i % 2));
            chk($sformatf("abort_quiet%0d", i), 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        end
        data1 = 32'h99AABBCC;
        cyc(1'b0, 1'b1, 1'b0);
        chk("abort_fresh_gnt1", 0, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, eb(32'h99AABBCC, 1, 0)));
        serve_rest(0, 1'b0, 1'b0, 32'h99AABBCC, 1, 4);

        // NBYTES=1 instance: a single C3 payload byte, then done0.
        do_reset();
        data0 = 32'h000000C3;
        cyc(1'b1, 1'b0, 1'b0);
        chk("nb1_gnt0", 1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, eb(32'h000000C3, 0, 0)));
        serve_rest(1, 1'b0, 1'b0, 32'h000000C3, 0, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("nb1_idle", 1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3));

        $display("Result: errors=%0d of %0d checks", nerr, ncheck);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter NBYTES, default 4, the number of payload bytes sent per request (legal range 1..4).
REQ-002 SHALL have port clk, input, 1 bit, system clock.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port req0 / req1, input, 1 bit each, level request from requester 0 / 1.
REQ-005 SHALL have port data0 / data1, input, 32 bits each, payload word of each requester, sampled at grant.
REQ-006 SHALL have port gnt0 / gnt1, output, 1 bit each, one-cycle pulse marking payload capture.
REQ-007 SHALL have port done0 / done1, output, 1 bit each, one-cycle pulse after the last byte of that requester's frame completes.
REQ-008 SHALL have port tx_start, output, 1 bit, one-cycle start strobe to the UART transmitter.
REQ-009 SHALL have port din, output, 8 bits, byte presented to the transmitter.
REQ-010 SHALL have port tx_done, input, 1 bit, transmitter stop-bit completion pulse.
REQ-011 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, SEND and WAIT; all outputs SHALL be registered.
REQ-013 In IDLE with any req high at a clock edge: SHALL capture the granted data word, move to SEND, and in the next cycle drive gnt for that requester, tx_start=1 and din=byte 0.
REQ-014 SHALL arbitrate round-robin: with both req high, grant the requester not served last; the last-served pointer resets so that requester 0 wins first; with one req high, grant it regardless of the pointer.
REQ-015 SHALL keep SEND for exactly one cycle, then enter WAIT with tx_start=0 and din held stable.
REQ-016 SHALL send bytes LSB first: byte k = data[8k+7:8k], k = 0..NBYTES-1.
REQ-017 In WAIT, when tx_done is sampled high and bytes remain: SHALL go to SEND with the next byte on din and tx_start=1 in the following cycle.
REQ-018 In WAIT, when tx_done is sampled high on the last byte: SHALL go to IDLE and pulse done for the served requester in the following cycle.
REQ-019 SHALL ignore tx_done in IDLE and SEND, ignore req outside IDLE, and ignore data changes after capture.
REQ-020 A req dropped before its grant SHALL be discarded with no gnt or done.
REQ-021 A req already high in the done-pulse cycle SHALL be granted, with SEND starting on the next cycle; there are no idle gap cycles beyond this.
REQ-022 gnt0/gnt1 and done0/done1 SHALL never be high in the same cycle, and tx_start SHALL never be high in consecutive cycles.

Reset
REQ-023 On reset: state=IDLE; tx_start, gnt0, gnt1, done0, done1 and busy = 0; din = 8'h00; byte counter = 0; RR pointer = requester 1 last served.
REQ-024 Reset mid-frame SHALL abort immediately with no done pulse; the aborted frame SHALL NOT be resumed.

Configuration
REQ-025 With UART_TXSCHED_HDR_EN defined: each frame SHALL be prefixed with header byte 8'hA0 | id (id = 0/1), sent before payload byte 0, for NBYTES+1 bytes per frame.
REQ-026 Without UART_TXSCHED_HDR_EN: no header SHALL be sent and frames SHALL be exactly NBYTES bytes.

Verification
REQ-027 Single request: req0=1, data0=32'h11223344, tx_done pulsed per byte -> din sequence 44,33,22,11, four tx_start pulses, one gnt0, then done0.
REQ-028 Contention: req0 and req1 high together from reset -> requester 0 served first; req1 granted in the done0 cycle; next simultaneous request -> requester 0 served again (pointer now at 1).
REQ-029 Spurious tx_done: tx_done pulsed in IDLE and in SEND -> no state change and no extra tx_start.
REQ-030 Reset mid-frame: assert reset after byte 1 -> all outputs at reset values, no done; req1 afterwards -> fresh frame starting from byte 0.
REQ-031 Header build: with UART_TXSCHED_HDR_EN, req1 and data1=32'hDEADBEEF -> din sequence A1,EF,BE,AD,DE, then done1.
REQ-032 NBYTES=1: req0 and data0=32'h000000C3 -> a single C3 byte and a single tx_start, then done0.
